// File: rtl/multi_chatter_filter.sv
// Multi-channel debouncer for active-low switches with press/release/long-press pulses and toggle state.
// Define CHATTER_SYNC_EN to insert a 2-flop synchroniser (reset to released) ahead of each filter.
module multi_chatter_filter #(
    parameter int CHANNELS      = 4,
    parameter int CNT_WIDTH     = 8,
    parameter int PRESS_COUNT   = 5,
    parameter int RELEASE_COUNT = 3,
    parameter int LONG_COUNT    = 20
) (
    input  logic                chatterclock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] switchin,
    output logic [CHANNELS-1:0] ispressed,
    output logic [CHANNELS-1:0] enabled,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] long_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] PRESS_LAST   = CNT_WIDTH'(PRESS_COUNT - 1);
    localparam logic [CNT_WIDTH-1:0] RELEASE_LAST = CNT_WIDTH'(RELEASE_COUNT - 1);
    localparam logic [CNT_WIDTH-1:0] LONG_LAST    = CNT_WIDTH'(LONG_COUNT - 1);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + CNT_WIDTH'(1);
    endfunction

    logic [CHANNELS-1:0] sampled;

`ifdef CHATTER_SYNC_EN
    logic [CHANNELS-1:0] sync_a;
    logic [CHANNELS-1:0] sync_b;

    always_ff @(posedge chatterclock or posedge reset) begin
        if (reset) begin
            sync_a <= '1;
            sync_b <= '1;
        end else begin
            sync_a <= switchin;
            sync_b <= sync_a;
        end
    end

    assign sampled = sync_b;
`else
    assign sampled = switchin;
`endif

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        state_t               state;
        state_t               state_nx;
        logic [CNT_WIDTH-1:0] cnt;
        logic [CNT_WIDTH-1:0] cnt_nx;
        logic [CNT_WIDTH-1:0] rcnt;
        logic [CNT_WIDTH-1:0] rcnt_nx;
        logic                 pressed_q;
        logic                 pressed_nx;
        logic                 enabled_q;
        logic                 enabled_nx;
        logic                 press_q;
        logic                 press_nx;
        logic                 release_q;
        logic                 release_nx;
        logic                 long_q;
        logic                 long_nx;
        logic                 p;

        assign p = ~sampled[g];

        always_ff @(posedge chatterclock or posedge reset) begin
            if (reset) begin
                state     <= ST_IDLE;
                cnt       <= '0;
                rcnt      <= '0;
                pressed_q <= 1'b0;
                enabled_q <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                state     <= state_nx;
                cnt       <= cnt_nx;
                rcnt      <= rcnt_nx;
                pressed_q <= pressed_nx;
                enabled_q <= enabled_nx;
                press_q   <= press_nx;
                release_q <= release_nx;
                long_q    <= long_nx;
            end
        end

        always_comb begin
            state_nx   = state;
            cnt_nx     = cnt;
            rcnt_nx    = rcnt;
            pressed_nx = pressed_q;
            enabled_nx = enabled_q;
            press_nx   = 1'b0;
            release_nx = 1'b0;
            long_nx    = 1'b0;

            case (state)
                ST_IDLE: begin
                    if (p) begin
                        if (cnt == PRESS_LAST) begin
                            state_nx   = ST_PRESSED;
                            pressed_nx = 1'b1;
                            enabled_nx = ~enabled_q;
                            press_nx   = 1'b1;
                            cnt_nx     = '0;
                            rcnt_nx    = '0;
                        end else begin
                            cnt_nx = sat_inc(cnt);
                        end
                    end else begin
                        cnt_nx = '0;
                    end
                end
                ST_PRESSED, ST_LONG: begin
                    // Release is checked first so it pre-empts a coincident long-press.
                    if (!p && rcnt == RELEASE_LAST) begin
                        state_nx   = ST_IDLE;
                        pressed_nx = 1'b0;
                        release_nx = 1'b1;
                        cnt_nx     = '0;
                        rcnt_nx    = '0;
                    end else begin
                        rcnt_nx = p ? '0 : sat_inc(rcnt);
                        if (state == ST_PRESSED) begin
                            cnt_nx = sat_inc(cnt);
                            if (cnt == LONG_LAST) begin
                                state_nx = ST_LONG;
                                long_nx  = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_nx   = ST_IDLE;
                    pressed_nx = 1'b0;
                    cnt_nx     = '0;
                    rcnt_nx    = '0;
                end
            endcase
        end

        assign ispressed[g]     = pressed_q;
        assign enabled[g]       = enabled_q;
        assign press_pulse[g]   = press_q;
        assign release_pulse[g] = release_q;
        assign long_pulse[g]    = long_q;
    end

endmodule

// File: tb/tb_multi_chatter_filter.sv
// Bench for multi_chatter_filter: history-based reference model compared every cycle plus directed literal checks.
module tb_multi_chatter_filter;

    localparam int CH  = 4;
    localparam int PC  = 5;
    localparam int RC  = 3;
    localparam int LC  = 20;
    localparam int MAXT = 2048;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [CH-1:0] switchin = '1;
    logic [CH-1:0] ispressed, enabled, press_pulse, release_pulse, long_pulse;

    int checks = 0;
    int passes = 0;

    multi_chatter_filter #(
        .CHANNELS(CH),
        .CNT_WIDTH(8),
        .PRESS_COUNT(PC),
        .RELEASE_COUNT(RC),
        .LONG_COUNT(LC)
    ) dut (
        .chatterclock(clk),
        .reset(reset),
        .switchin(switchin),
        .ispressed(ispressed),
        .enabled(enabled),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .long_pulse(long_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: keeps the sampled pressed-history of every channel and decides
    // events by looking back over runs of equal samples since the last boundary.
    bit            hist [CH][MAXT];
    int            t = 0;
    int            bnd [CH];
    int            acc_t [CH];
    bit            long_done [CH];
    logic [CH-1:0] e_pr = '0, e_en = '0, e_pp = '0, e_rp = '0, e_lp = '0;

    function automatic bit run_of(input int c, input bit v, input int n);
        if (t - n + 1 < bnd[c]) return 1'b0;
        for (int k = 0; k < n; k++)
            if (hist[c][t-k] != v) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CH; c++) begin
                bnd[c] = t;
                long_done[c] = 1'b0;
            end
            e_pr = '0; e_en = '0; e_pp = '0; e_rp = '0; e_lp = '0;
        end else if (t < MAXT) begin
            e_pp = '0; e_rp = '0; e_lp = '0;
            for (int c = 0; c < CH; c++) begin
                hist[c][t] = ~switchin[c];
                if (!e_pr[c]) begin
                    if (run_of(c, 1'b1, PC)) begin
                        e_pr[c] = 1'b1;
                        e_en[c] = ~e_en[c];
                        e_pp[c] = 1'b1;
                        acc_t[c] = t;
                        bnd[c] = t + 1;
                        long_done[c] = 1'b0;
                    end
                end else if (run_of(c, 1'b0, RC)) begin
                    e_pr[c] = 1'b0;
                    e_rp[c] = 1'b1;
                    bnd[c] = t + 1;
                end else if (!long_done[c] && t - acc_t[c] == LC) begin
                    e_lp[c] = 1'b1;
                    long_done[c] = 1'b1;
                end
            end
            t++;
        end
    end

    int n_long [CH];
    int n_rel  [CH];

    initial begin
        for (int c = 0; c < CH; c++) begin
            n_long[c] = 0;
            n_rel[c] = 0;
        end
    end

    always @(negedge clk) begin
        chk("ispressed", ispressed, e_pr);
        chk("enabled", enabled, e_en);
        chk("press_pulse", press_pulse, e_pp);
        chk("release_pulse", release_pulse, e_rp);
        chk("long_pulse", long_pulse, e_lp);
        for (int c = 0; c < CH; c++) begin
            n_long[c] += int'(long_pulse[c]);
            n_rel[c]  += int'(release_pulse[c]);
        end
    end

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset state
        ticks(2);
        chk("reset_outputs", {ispressed, enabled, press_pulse, release_pulse, long_pulse}, 32'h0);
        reset = 1'b0;

        // Clean press on channel 0
        switchin[0] = 1'b0;
        ticks(4);
        chk("ch0_not_yet", ispressed, 4'b0000);
        ticks(1);
        chk("ch0_pressed", ispressed, 4'b0001);
        chk("ch0_press_pulse", press_pulse, 4'b0001);
        chk("ch0_enabled", enabled, 4'b0001);
        ticks(1);
        chk("ch0_pulse_one_cycle", press_pulse, 4'b0000);

        // Press chatter on channel 1
        switchin[1] = 1'b0;
        ticks(4);
        chk("ch1_four_lows", ispressed[1], 1'b0);
        switchin[1] = 1'b1;
        ticks(1);
        chk("ch1_glitch", ispressed[1], 1'b0);
        switchin[1] = 1'b0;
        ticks(4);
        chk("ch1_four_again", ispressed[1], 1'b0);
        ticks(1);
        chk("ch1_accepted", ispressed[1], 1'b1);
        chk("ch1_press_pulse", press_pulse, 4'b0010);

        // Release filtering and toggle on channel 2
        switchin[2] = 1'b0;
        ticks(5);
        chk("ch2_pressed", {ispressed[2], enabled[2]}, 2'b11);
        switchin[2] = 1'b1;
        ticks(2);
        switchin[2] = 1'b0;
        ticks(1);
        switchin[2] = 1'b1;
        ticks(2);
        chk("ch2_rel_filtered", {ispressed[2], release_pulse[2]}, 2'b10);
        ticks(1);
        chk("ch2_released", {ispressed[2], release_pulse[2], enabled[2]}, 3'b011);
        switchin[2] = 1'b0;
        ticks(5);
        chk("ch2_toggle_off", {ispressed[2], enabled[2]}, 2'b10);
        switchin[2] = 1'b1;
        ticks(3);
        chk("ch2_released2", {ispressed[2], release_pulse[2]}, 2'b01);

        // Long press on channel 3, then long hold
        switchin[3] = 1'b0;
        ticks(5);
        chk("ch3_press_pulse", press_pulse[3], 1'b1);
        ticks(19);
        chk("ch3_long_early", long_pulse[3], 1'b0);
        ticks(1);
        chk("ch3_long_pulse", long_pulse[3], 1'b1);
        ticks(300);
        chk("ch3_long_once", n_long[3], 32'd1);
        chk("ch0_long_once", n_long[0], 32'd1);
        chk("ch3_still_pressed", ispressed[3], 1'b1);
        switchin[3] = 1'b1;
        ticks(3);
        chk("ch3_released", release_pulse[3], 1'b1);

        // Asynchronous reset while channel 0 is in LONG
        #2 reset = 1'b1;
        #1 chk("async_reset", {ispressed, enabled, press_pulse, release_pulse, long_pulse}, 32'h0);
        ticks(1);
        reset = 1'b0;
        ticks(4);
        chk("ch0_post_reset_wait", ispressed[0], 1'b0);
        ticks(1);
        chk("ch0_post_reset_press", {ispressed[0], enabled[0]}, 2'b11);
        chk("ch0_no_release", n_rel[0], 32'd0);
        ticks(2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multi_chatter_filter.md
Name: multi_chatter_filter

Overview:
- Multi-channel, parametrised switch debouncer for active-low push switches, sampled on a slow chatter clock.
- Per channel it produces:
  - a debounced level, `ispressed`;
  - a toggle state, `enabled`, that flips once per press;
  - one-cycle press, release and long-press pulses.
- Sits between raw board switches and the control logic.
- Replaces single-channel press-only counters with symmetric press/release filtering, a saturating counter, and fully synchronous toggling.

Parameters:
- CHANNELS, 4: number of independent switch channels.
- CNT_WIDTH, 8: width of each per-channel counter.
- PRESS_COUNT, 5: consecutive low samples needed to accept a press (1 .. 2^CNT_WIDTH-1).
- RELEASE_COUNT, 3: consecutive high samples needed to accept a release (1 .. 2^CNT_WIDTH-1).
- LONG_COUNT, 20: cycles in PRESSED, counted after the press is accepted, before a long press is flagged (1 .. 2^CNT_WIDTH-1).

Ports:
- chatterclock  in  1  sampling clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- switchin  in  CHANNELS  raw switch levels; 0 = pressed.
- ispressed  out  CHANNELS  debounced pressed level, registered.
- enabled  out  CHANNELS  toggle state, registered.
- press_pulse  out  CHANNELS  one-cycle pulse when a press is accepted.
- release_pulse  out  CHANNELS  one-cycle pulse when a release is accepted.
- long_pulse  out  CHANNELS  one-cycle pulse when a held press reaches LONG_COUNT.

Behaviour:
- **Clocking and reset:** one clock, chatterclock. reset is asynchronous and active-high.
- **Reset state:** every output 0, all counters 0, every channel in IDLE.
- **Channel independence:** channels are fully independent; no shared state. The rules below apply per channel i.
- **Sampled input:** s = switchin[i], or its synchronised copy (see Optional Feature). p = ~s.
- **States:** IDLE, PRESSED, LONG. Each channel has two counters, cnt and rcnt, both CNT_WIDTH wide and saturating (never wrap).
- **IDLE:**
  - p=1: cnt increments.
  - p=0: cnt clears to 0.
  - On the edge sampling the PRESS_COUNT-th consecutive p=1 (i.e. cnt == PRESS_COUNT-1 and p=1):
    - go to PRESSED;
    - ispressed <= 1;
    - press_pulse=1 for exactly that cycle;
    - enabled toggles on the same edge;
    - cnt <= 0, rcnt <= 0.
- **PRESSED:**
  - cnt increments every cycle, saturating at all-ones.
  - p=0: rcnt increments; any p=1 sample clears rcnt to 0 (chatter during release restarts the filter).
  - When cnt == LONG_COUNT-1 on an edge (LONG_COUNT cycles after acceptance):
    - long_pulse=1 for one cycle;
    - go to LONG.
- **LONG:** ispressed stays 1; rcnt behaves as in PRESSED; cnt is frozen.
- **Release (from PRESSED or LONG):** on the edge sampling the RELEASE_COUNT-th consecutive p=0 (rcnt == RELEASE_COUNT-1 and p=0):
  - go to IDLE;
  - ispressed <= 0;
  - release_pulse=1 for one cycle;
  - cnt <= 0, rcnt <= 0;
  - enabled is unchanged.
- **Simultaneous events:** if the long and release conditions occur on the same edge in PRESSED, release wins and no long_pulse is issued.
- **PRESS_COUNT=1:** a single low sample is accepted as a press. The same applies to RELEASE_COUNT=1 for a single high sample.
- **Pulses:** registered; they never overlap for one channel and are never asserted for two consecutive cycles.
- **No derived clocks:** enabled is updated only on chatterclock, never clocked by ispressed.
- **Reset mid-press:** returns the channel to IDLE with ispressed=0 and enabled=0, and emits no release_pulse. A switch still held after reset deasserts needs a full PRESS_COUNT samples to register.

Optional Feature:
- Macro: CHATTER_SYNC_EN.
- **Defined:**
  - each switchin bit passes through a 2-flop synchroniser before filtering;
  - the synchroniser flops reset to 1 (released);
  - all press/release latencies grow by exactly 2 cycles.
- **Undefined:** switchin feeds the filter directly; the latencies are exactly as stated in Behaviour.

Test Plan (defaults, CHANNELS=4, CHATTER_SYNC_EN undefined):
- Clean press: hold switchin[0]=0 from edge 0 -> ispressed[0]=1, press_pulse[0]=1 and enabled[0]=1 after edge 4. Other channels stay 0.
- Press chatter: switchin[1] low for 4 cycles, high for 1, then low -> no press after the first 4 lows. Press accepted after the 5th consecutive low.
- Release filtering, then toggle: press channel 2, then release with one high-low glitch -> release_pulse only after 3 consecutive highs, enabled[2] still 1. A second full press -> enabled[2]=0.
- Long press: hold channel 3 low -> long_pulse[3] exactly once, 20 cycles after press acceptance. Still exactly one pulse when held 300 cycles (counter saturates, no wrap).
- Reset mid-press: assert reset while channel 0 is in LONG -> all outputs 0 immediately (asynchronous), no release_pulse. With the switch still held after reset release, ispressed[0] rises again 5 cycles later.
- With CHATTER_SYNC_EN defined, repeat clean press -> ispressed[0] rises after edge 6.
